// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 slice.
//   - CP0 register numbers used by mtc0/mfc0
//   - ExcCode values delivered by the pipeline's exception detection
//   - exception handler entry address
//   - bit positions of the SR and Cause fields
//   - word_align(): clears the two low address bits
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int IM_LSB  = 10;
    localparam int IM_MSB  = 15;
    localparam int IP_LSB  = 10;
    localparam int IP_MSB  = 15;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_LSB = 2;
    localparam int EXC_MSB = 6;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// cp0_req_arb: combinational exception/interrupt arbitration.
// Ports:
//   hwint_i     hardware interrupt lines
//   im_i        SR.IM interrupt mask
//   ie_i        SR.IE global interrupt enable
//   exl_i       SR.EXL; while set, every request is masked
//   exc_code_i  accumulated M-stage exception code (0 = none)
//   int_req_o   an enabled interrupt is pending
//   exc_req_o   a synchronous exception is pending
//   req_o       a request is taken this cycle
//   code_o      ExcCode to record; an interrupt wins over an exception
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hwint_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [4:0] exc_code_i,
    output logic       int_req_o,
    output logic       exc_req_o,
    output logic       req_o,
    output logic [4:0] code_o
);

    always_comb begin
        int_req_o = ie_i & ~exl_i & (|(hwint_i & im_i));
        exc_req_o = (exc_code_i != 5'd0) & ~exl_i;
        req_o     = int_req_o | exc_req_o;
        code_o    = int_req_o ? EXC_INT : exc_code_i;
    end

endmodule

// File: rtl/cp0.sv
// cp0: coprocessor-0 register file and exception/interrupt controller,
// evaluated at the M-stage commit point.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   en          mtc0 write enable
//   CP0Add      register number for mfc0/mtc0
//   CP0In       mtc0 write data
//   CP0Out      mfc0 read data (combinational)
//   VPC         PC of the M-stage instruction or bubble
//   BDIn        M-stage instruction sits in a branch delay slot
//   ExcCodeIn   accumulated exception code (0 = none)
//   HWInt       hardware interrupt lines
//   EXLClr      eret at the M stage
//   EPCOut      current EPC, the eret target
//   Req         request taken this cycle (pipeline flushes to the handler)
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h2023_0001,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req, exc_req;
    logic [4:0]  code;

    cp0_req_arb u_arb (
        .hwint_i    (HWInt),
        .im_i       (im_q),
        .ie_i       (ie_q),
        .exl_i      (exl_q),
        .exc_code_i (ExcCodeIn),
        .int_req_o  (int_req),
        .exc_req_o  (exc_req),
        .req_o      (Req),
        .code_o     (code)
    );

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (Req) begin
            // The faulting instruction does not commit, so any mtc0 or eret
            // it carries is discarded here.
            exc_d = code;
            bd_d  = BDIn;
            exl_d = 1'b1;
            epc_d = word_align(BDIn ? (VPC - 32'd4) : VPC);
        end else begin
            if (en && (CP0Add == CP0_SR)) begin
                im_d  = CP0In[IM_MSB:IM_LSB];
                exl_d = CP0In[EXL_BIT];
                ie_d  = CP0In[IE_BIT];
            end
            if (en && (CP0Add == CP0_EPC)) begin
                epc_d = word_align(CP0In);
            end
            // eret clears EXL after any same-cycle SR write.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= SR_RESET[IM_MSB:IM_LSB];
            exl_q <= SR_RESET[EXL_BIT];
            ie_q  <= SR_RESET[IE_BIT];
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    logic [31:0] sr_word, cause_word;

    always_comb begin
        sr_word                 = 32'd0;
        sr_word[IM_MSB:IM_LSB]  = im_q;
        sr_word[EXL_BIT]        = exl_q;
        sr_word[IE_BIT]         = ie_q;
        cause_word                  = 32'd0;
        cause_word[BD_BIT]          = bd_q;
        cause_word[IP_MSB:IP_LSB]   = ip_q;
        cause_word[EXC_MSB:EXC_LSB] = exc_q;
        case (CP0Add)
            CP0_SR:    CP0Out = sr_word;
            CP0_CAUSE: CP0Out = cause_word;
            CP0_EPC:   CP0Out = epc_q;
            CP0_PRID:  CP0Out = PRID;
            default:   CP0Out = 32'd0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule
